// File: rtl/sg90_pkg.sv
// sg90 arbiter shared types and duty limits.
// Optional SG90_RETARGET_EN lets the owner retarget during a ramp.
package sg90_pkg;

  typedef logic [7:0] duty_t;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    DONE
  } state_t;

  localparam duty_t DUTY_MIN  = 8'd1;
  localparam duty_t DUTY_MAX  = 8'd99;
  localparam duty_t DUTY_INIT = 8'd50;

  function automatic duty_t clamp_duty(duty_t d);
    if (d < DUTY_MIN) return DUTY_MIN;
    if (d > DUTY_MAX) return DUTY_MAX;
    return d;
  endfunction

endpackage

// File: rtl/sg90_if.sv
// Two-requester valid/ready bundle for the sg90 arbiter.
// Master is the requester side, slave is the arbiter.
interface sg90_if;
  import sg90_pkg::*;

  logic  req_a_valid;
  duty_t req_a_duty;
  logic  req_a_ready;
  logic  req_b_valid;
  duty_t req_b_duty;
  logic  req_b_ready;

  modport master (
    output req_a_valid, req_a_duty,
    output req_b_valid, req_b_duty,
    input  req_a_ready, req_b_ready
  );

  modport slave (
    input  req_a_valid, req_a_duty,
    input  req_b_valid, req_b_duty,
    output req_a_ready, req_b_ready
  );

endinterface

// File: rtl/sg90_frame_tick.sv
// Free-running servo frame counter.
// Emits a one-cycle tick on the last count of each frame.
module sg90_frame_tick #(
  parameter int CLK_FRE  = 50,
  parameter int FRAME_US = 20000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [23:0] TIME_FRAME = 24'(FRAME_US * CLK_FRE - 1);

  logic [23:0] cnt;

  assign tick = (cnt == TIME_FRAME);

  // count up, wrap to zero on the tick
  always_ff @(posedge clk) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 24'd1;
  end

endmodule

// File: rtl/sg90_arb.sv
// Round-robin two-requester servo duty arbiter with per-frame ramp.
// Optional SG90_RETARGET_EN: owner may retarget while ramping.
module sg90_arb
  import sg90_pkg::*;
#(
  parameter int CLK_FRE  = 50,
  parameter int FRAME_US = 20000
) (
  input  logic  clk,
  input  logic  rst_n,
  sg90_if.slave bus,
  output duty_t sg90_duty,
  output logic  busy,
  output logic  done,
  output logic  grant_id
);

  state_t state, state_nx;
  duty_t  target, target_nx;
  duty_t  duty_nx;
  logic   grant_nx;
  logic   tick;
  logic   idle, ramp;
  logic   a_rt, b_rt;
  logic   take;
  duty_t  req_clamped;

  sg90_frame_tick #(
    .CLK_FRE  (CLK_FRE),
    .FRAME_US (FRAME_US)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign idle = (state == IDLE);
  assign ramp = (state == RAMP);

`ifdef SG90_RETARGET_EN
  assign a_rt = ramp & bus.req_a_valid & ~grant_id;
  assign b_rt = ramp & bus.req_b_valid &  grant_id;
`else
  assign a_rt = 1'b0;
  assign b_rt = 1'b0;
`endif

  assign bus.req_a_ready =
    (idle & bus.req_a_valid & (~bus.req_b_valid | grant_id)) | a_rt;
  assign bus.req_b_ready =
    (idle & bus.req_b_valid & (~bus.req_a_valid | ~grant_id)) | b_rt;

  assign take = bus.req_a_ready | bus.req_b_ready;

  assign req_clamped = clamp_duty(
    bus.req_a_ready ? bus.req_a_duty : bus.req_b_duty);

  assign busy = ~idle;
  assign done = (state == DONE);

  // next state, target, grant and duty step
  always_comb begin
    state_nx  = state;
    target_nx = target;
    duty_nx   = sg90_duty;
    grant_nx  = grant_id;
    if (take) begin
      target_nx = req_clamped;
      grant_nx  = bus.req_b_ready;
    end
    unique case (state)
      IDLE: begin
        if (take)
          state_nx = (req_clamped != sg90_duty) ? RAMP : DONE;
      end
      RAMP: begin
        if (!take) begin
          if (sg90_duty == target)
            state_nx = DONE;
          else if (tick)
            duty_nx = (sg90_duty < target) ?
                      sg90_duty + 8'd1 : sg90_duty - 8'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state, target, duty and grant registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      target    <= DUTY_INIT;
      sg90_duty <= DUTY_INIT;
      grant_id  <= 1'b1;
    end else begin
      state     <= state_nx;
      target    <= target_nx;
      sg90_duty <= duty_nx;
      grant_id  <= grant_nx;
    end
  end

endmodule

// File: tb/tb_sg90_arb.sv
// Bench for sg90_arb: request table, corner sequences, random traffic.
// Outputs are compared each cycle against a transaction-level model.
module tb_sg90_arb;
  import sg90_pkg::*;

`ifdef SG90_RETARGET_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  duty_t sg90_duty;
  logic  busy, done, grant_id;

  sg90_if bus();

  sg90_arb #(
    .CLK_FRE  (1),
    .FRAME_US (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sg90_duty (sg90_duty),
    .busy      (busy),
    .done      (done),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampd(int d);
    return (d < 1) ? 1 : ((d > 99) ? 99 : d);
  endfunction

  function automatic int absd(int d);
    return (d < 0) ? -d : d;
  endfunction

  // model: phase 0 waiting, 1 moving, 2 reporting completion
  int m_duty = 50;
  int m_tgt = 50;
  int m_grant = 1;
  int m_phase = 0;
  int fc = 0;
  int tick_cnt = 0;
  bit chk_en = 1'b0;
  bit m_t, m_ea, m_eb;
  int m_nd;

  function automatic bit exp_a();
    return (m_phase == 0 && bus.req_a_valid &&
            (!bus.req_b_valid || m_grant == 1)) ||
           (RT && m_phase == 1 && bus.req_a_valid && m_grant == 0);
  endfunction

  function automatic bit exp_b();
    return (m_phase == 0 && bus.req_b_valid &&
            (!bus.req_a_valid || m_grant == 0)) ||
           (RT && m_phase == 1 && bus.req_b_valid && m_grant == 1);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_duty = 50; m_tgt = 50; m_grant = 1; m_phase = 0; fc = 0;
    end else begin
      m_ea = exp_a();
      m_eb = exp_b();
      m_t = (fc == 9);
      fc = m_t ? 0 : fc + 1;
      if (m_t) tick_cnt++;
      if (m_ea || m_eb) begin
        m_nd = clampd(m_ea ? int'(bus.req_a_duty) : int'(bus.req_b_duty));
        if (m_phase == 0) m_phase = (m_nd != m_duty) ? 1 : 2;
        m_tgt = m_nd;
        m_grant = m_eb ? 1 : 0;
      end else if (m_phase == 1) begin
        if (m_duty == m_tgt) m_phase = 2;
        else if (m_t) m_duty += (m_tgt > m_duty) ? 1 : -1;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_a_ready", bus.req_a_ready, exp_a());
      chk("m_b_ready", bus.req_b_ready, exp_b());
      chk("m_duty", sg90_duty, m_duty);
      chk("m_busy", busy, m_phase != 0);
      chk("m_done", done, m_phase == 2);
      chk("m_grant", grant_id, m_grant);
    end
  end

  task automatic drop_all();
    bus.req_a_valid = 0; bus.req_a_duty = 0;
    bus.req_b_valid = 0; bus.req_b_duty = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    drop_all();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  typedef struct {
    bit av; int ad; bit bv; int bd;
    int first_id; int final_duty; int total_ticks; int n_done;
  } row_t;

  task automatic serve_row(input row_t r, input int idx);
    int ndone, tt, t0, nd, st, side, k, idle_cyc;
    bit first;
    ndone = 0; tt = 0; first = 1; idle_cyc = 0;
    do_reset();
    bus.req_a_valid = r.av; bus.req_a_duty = 8'(r.ad);
    bus.req_b_valid = r.bv; bus.req_b_duty = 8'(r.bd);
    while ((bus.req_a_valid || bus.req_b_valid) && idle_cyc < 30) begin
      @(negedge clk);
      if ((bus.req_a_ready && bus.req_a_valid) ||
          (bus.req_b_ready && bus.req_b_valid)) begin
        idle_cyc = 0;
        side = bus.req_b_ready ? 1 : 0;
        if (first) begin
          chk($sformatf("row%0d_first", idx), side, r.first_id);
          first = 0;
        end
        nd = clampd(side ? int'(bus.req_b_duty) : int'(bus.req_a_duty));
        st = int'(sg90_duty);
        @(posedge clk); #1;
        if (side) bus.req_b_valid = 0;
        else bus.req_a_valid = 0;
        @(negedge clk);
        t0 = tick_cnt;
        k = 0;
        while (!done && k < 2000) begin
          @(negedge clk);
          k++;
        end
        if (!done) begin
          chk($sformatf("row%0d_done_timeout", idx), 0, 1);
        end else begin
          ndone++;
          chk($sformatf("row%0d_done_duty", idx), sg90_duty, nd);
          chk($sformatf("row%0d_ticks", idx), tick_cnt - t0, absd(nd - st));
          tt += tick_cnt - t0;
        end
      end else begin
        idle_cyc++;
      end
    end
    chk($sformatf("row%0d_final", idx), sg90_duty, r.final_duty);
    chk($sformatf("row%0d_total_ticks", idx), tt, r.total_ticks);
    chk($sformatf("row%0d_ndone", idx), ndone, r.n_done);
  endtask

  initial begin
    row_t rows[6];
    int k, ndone;

    rows[0] = '{1, 53, 0, 0,   0, 53, 3, 1};
    rows[1] = '{0, 0,  1, 40,  1, 40, 10, 1};
    rows[2] = '{0, 0,  1, 0,   1, 1,  49, 1};
    rows[3] = '{0, 0,  1, 200, 1, 99, 49, 1};
    rows[4] = '{1, 50, 0, 0,   0, 50, 0, 1};
    rows[5] = '{1, 60, 1, 40,  0, 40, 30, 2};

    drop_all();
    @(posedge clk); #1;
    rst_n = 1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_duty", sg90_duty, 50);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_grant", grant_id, 1);

    for (int i = 0; i < 6; i++) serve_row(rows[i], i);

    // reset in the middle of a ramp toward 70
    do_reset();
    bus.req_a_valid = 1; bus.req_a_duty = 70;
    k = 0;
    while (sg90_duty != 57 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reach57", sg90_duty, 57);
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("mid_rst_duty", sg90_duty, 50);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", bus.req_a_ready, 1);

    // second target arrives while the first ramp is under way
    do_reset();
    bus.req_a_valid = 1; bus.req_a_duty = 70;
    @(negedge clk);
    chk("rt_first_ready", bus.req_a_ready, 1);
    @(posedge clk); #1;
    bus.req_a_valid = 0;
    ndone = 0;
    k = 0;
    while (sg90_duty != 55 && k < 2000) begin
      @(negedge clk);
      if (done) ndone++;
      k++;
    end
    chk("rt_reach55", sg90_duty, 55);
    @(posedge clk); #1;
    bus.req_a_valid = 1; bus.req_a_duty = 45;
    @(negedge clk);
    chk("rt_ready_in_ramp", bus.req_a_ready, RT);
    k = 0;
    while (!(done && !bus.req_a_valid && sg90_duty == 45) && k < 3000) begin
      if (bus.req_a_ready && bus.req_a_valid) begin
        @(posedge clk); #1;
        bus.req_a_valid = 0;
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
      if (done) ndone++;
      k++;
    end
    chk("rt_final", sg90_duty, 45);
    chk("rt_ndone", ndone, RT ? 1 : 2);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 9) < 3) bus.req_a_valid = $urandom_range(0, 1);
      if ($urandom_range(0, 9) < 3) bus.req_b_valid = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0)
        bus.req_a_duty = ($urandom_range(0, 9) == 0) ?
          8'($urandom_range(0, 255)) : 8'($urandom_range(44, 56));
      if ($urandom_range(0, 3) == 0)
        bus.req_b_duty = ($urandom_range(0, 9) == 0) ?
          8'($urandom_range(0, 255)) : 8'($urandom_range(44, 56));
    end

    @(negedge clk);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sg90_arb.md
SG90_ARB -- requirements
Module: sg90_arb

Interface
REQ-001 Parameter CLK_FRE, default 50, clock frequency in MHz, SHALL be provided.
REQ-002 Parameter FRAME_US, default 20000, SHALL set the servo frame period in microseconds.
REQ-003 clk  input  1  SHALL be the sole clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 req_a_valid  input  1  SHALL flag that requester A has a target pending.
REQ-006 req_a_duty  input  8  SHALL carry requester A's target duty.
REQ-007 req_a_ready  output  1  SHALL acknowledge A; the transfer occurs when valid and ready are both 1.
REQ-008 req_b_valid, req_b_duty, req_b_ready SHALL mirror REQ-005..007 for requester B.
REQ-009 sg90_duty  output  8  SHALL be the current duty (1..99) driven to the PWM stage.
REQ-010 busy  output  1  SHALL be 1 while the state is not IDLE.
REQ-011 done  output  1  SHALL pulse for one cycle when the target is reached.
REQ-012 grant_id  output  1  SHALL hold the last accepted requester (0=A, 1=B).

Function
REQ-013 Frame counter: 24-bit, counts 0..TIME_FRAME with TIME_FRAME = FRAME_US*CLK_FRE-1; on TIME_FRAME it produces a one-cycle tick and wraps to 0; it free-runs in all states.
REQ-014 FSM states: IDLE, RAMP, DONE.
REQ-015 The ready outputs SHALL be combinational: req_a_ready = IDLE & req_a_valid & (!req_b_valid | grant_id==1); req_b_ready = IDLE & req_b_valid & (!req_a_valid | grant_id==0).
REQ-016 Round-robin: when both requesters are valid, the one not equal to grant_id wins; at most one ready per cycle.
REQ-017 On acceptance, target <= clamp(req_duty, 1, 99) and grant_id <= the winner.
REQ-018 IDLE->RAMP next cycle if clamped target != sg90_duty; otherwise IDLE->DONE.
REQ-019 RAMP on tick: sg90_duty +1 if below target, -1 if above; one step per frame only.
REQ-020 RAMP->DONE on the cycle after sg90_duty equals target; DONE lasts one cycle with done=1, then IDLE.
REQ-021 Ramp latency SHALL equal |target - start duty| ticks (+1 cycle to DONE).
REQ-022 The tick and acceptance occurring in the same cycle SHALL NOT step the duty in that cycle.

Reset
REQ-023 On rst_n=0 at a clk edge: state=IDLE, sg90_duty=50, target=50, frame counter=0, done=0, grant_id=1 (A wins first).
REQ-024 Reset mid-RAMP SHALL abort the ramp and discard the target; duty returns to 50 immediately.

Configuration
REQ-025 Macro SG90_RETARGET_EN: when defined, in RAMP the requester equal to grant_id SHALL have ready=1 while valid; acceptance replaces target (clamped) and the state stays RAMP; the other requester waits.
REQ-026 When SG90_RETARGET_EN is undefined, both ready outputs SHALL be 0 outside IDLE.

Structure
REQ-027 Package sg90_pkg SHALL hold the state enum, the duty_t (8-bit) typedef and the constants DUTY_MIN=1, DUTY_MAX=99, DUTY_INIT=50.
REQ-028 The frame counter SHALL be the sub-module sg90_frame_tick (params CLK_FRE and FRAME_US; ports clk, rst_n, tick).

Verification (bench: CLK_FRE=1, FRAME_US=10 -> tick every 10 cycles)
REQ-029 After reset, A valid with duty 53 -> req_a_ready=1 for 1 cycle; duty 51, 52, 53 on three successive ticks; done pulses once; grant_id=0.
REQ-030 A and B valid simultaneously (A=60, B=40) after reset -> A is served first; B is accepted in the cycle after DONE; duty ends at 40.
REQ-031 B duty 0, then 200 -> target clamped to 1, then 99; sg90_duty never leaves 1..99.
REQ-032 Request duty 50 right after reset -> IDLE->DONE, done pulses on the next cycle, no duty change.
REQ-033 Reset asserted mid-ramp at duty 57 -> next cycle: duty=50, busy=0, ready recomputed from IDLE.
REQ-034 With SG90_RETARGET_EN: A=70 accepted, then A=45 at duty 55 -> ramp reverses and ends at 45 with a single done pulse; without the macro, req_a_ready=0 until done.
